// File: rtl/clk_int_div_strobe.sv
// Integer clock divider: registered clk_o with a rising-edge strobe and a
// ready/valid divider update applied only at period boundaries.
// Optional run enable (en_i) is compiled in with `define CLK_INT_DIV_GATE_EN.
module clk_int_div_strobe #(
  parameter int DIV_WIDTH   = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 div_valid_i,
  output logic                 div_ready_o,
  output logic                 clk_o,
  output logic                 clk_en_o
`ifdef CLK_INT_DIV_GATE_EN
  ,
  input  logic                 en_i
`endif
);

  logic [DIV_WIDTH-1:0] r_div;
  logic [DIV_WIDTH-1:0] r_pendDiv;
  logic                 r_pending;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic                 r_run;
  logic                 r_clk;
  logic                 r_clkEn;

  logic [DIV_WIDTH-1:0] w_neff;
  logic [DIV_WIDTH:0]   w_half;
  logic                 w_lastCnt;
  logic                 w_boundary;
  logic                 w_runNext;
  logic                 w_accept;

  // Divider values 0 and 1 cannot form a valid period, so they run as 2.
  assign w_neff    = (r_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : r_div;
  assign w_half    = ({1'b0, w_neff} + (DIV_WIDTH+1)'(1)) >> 1;
  assign w_lastCnt = r_run && (r_cnt == (w_neff - DIV_WIDTH'(1)));

  // While stopped (or just out of reset) every edge is a period boundary.
  assign w_boundary = w_lastCnt || !r_run;
  assign w_accept   = div_valid_i && !r_pending;

`ifdef CLK_INT_DIV_GATE_EN
  assign w_runNext = en_i;
`else
  assign w_runNext = 1'b1;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_div     <= DIV_WIDTH'(DEFAULT_DIV);
      r_pendDiv <= '0;
      r_pending <= 1'b0;
    end else if (w_boundary && r_pending) begin
      r_div     <= r_pendDiv;
      r_pending <= 1'b0;
    end else if (w_accept) begin
      r_pendDiv <= div_i;
      r_pending <= 1'b1;
    end
  end

  // Next output values are computed one cycle ahead so clk_o stays a pure flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_run   <= 1'b0;
      r_cnt   <= '0;
      r_clk   <= 1'b0;
      r_clkEn <= 1'b0;
    end else if (w_boundary) begin
      r_run   <= w_runNext;
      r_cnt   <= '0;
      r_clk   <= w_runNext;
      r_clkEn <= w_runNext;
    end else begin
      r_cnt   <= r_cnt + DIV_WIDTH'(1);
      r_clk   <= (({1'b0, r_cnt} + (DIV_WIDTH+1)'(1)) < w_half);
      r_clkEn <= 1'b0;
    end
  end

  assign div_ready_o = !r_pending;
  assign clk_o       = r_clk;
  assign clk_en_o    = r_clkEn;

endmodule

// File: tb/tb_clk_int_div_strobe.sv
// Scoreboard bench for clk_int_div_strobe: a waveform-queue reference model
// predicts clk_o/clk_en_o/div_ready_o each cycle; a negedge monitor compares.
module tb_clk_int_div_strobe;

  localparam int DIV_WIDTH   = 8;
  localparam int DEFAULT_DIV = 2;

  logic                 clk_i = 1'b0;
  logic                 rst_ni = 1'b1;
  logic [DIV_WIDTH-1:0] div_i = '0;
  logic                 div_valid_i = 1'b0;
  logic                 div_ready_o;
  logic                 clk_o;
  logic                 clk_en_o;
`ifdef CLK_INT_DIV_GATE_EN
  logic                 en_i = 1'b1;
`endif

  clk_int_div_strobe #(
    .DIV_WIDTH  (DIV_WIDTH),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .div_i      (div_i),
    .div_valid_i(div_valid_i),
    .div_ready_o(div_ready_o),
    .clk_o      (clk_o),
    .clk_en_o   (clk_en_o)
`ifdef CLK_INT_DIV_GATE_EN
    ,
    .en_i       (en_i)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    bit clk;
    bit en;
    bit rdy;
  } exp_t;

  exp_t     sb[$];
  bit [1:0] wave[$];
  int       mDiv = DEFAULT_DIV;
  int       mPendVal = 0;
  bit       mPend = 1'b0;
  int       compared = 0;
  int       mismatched = 0;

  // Reference model: at each period start the whole waveform of that period
  // is laid out in a queue, then consumed one entry per clock.
  always @(posedge clk_i) begin
    bit       accept;
    bit       runEn;
    bit [1:0] s;
    int       n;
    exp_t     e;
    if (rst_ni) begin
      accept = div_valid_i && !mPend;
`ifdef CLK_INT_DIV_GATE_EN
      runEn = en_i;
`else
      runEn = 1'b1;
`endif
      if (wave.size() == 0) begin
        if (mPend) begin
          mDiv  = mPendVal;
          mPend = 1'b0;
        end
        if (runEn) begin
          n = (mDiv < 2) ? 2 : mDiv;
          for (int i = 0; i < n; i++) wave.push_back({i < (n + 1) / 2, i == 0});
        end
      end
      if (accept) begin
        mPend    = 1'b1;
        mPendVal = int'(div_i);
      end
      s = (wave.size() != 0) ? wave.pop_front() : 2'b00;
      e.clk = s[1];
      e.en  = s[0];
      e.rdy = !mPend;
      sb.push_back(e);
    end
  end

  always @(negedge rst_ni) begin
    wave.delete();
    sb.delete();
    mDiv  = DEFAULT_DIV;
    mPend = 1'b0;
  end

  task automatic checkOutput();
    exp_t want;
    want = '{clk: 1'b0, en: 1'b0, rdy: 1'b1};
    if (rst_ni && sb.size() != 0) want = sb.pop_front();
    compared++;
    if (clk_o !== want.clk || clk_en_o !== want.en || div_ready_o !== want.rdy) begin
      mismatched++;
      $display("[TB] FAIL cycle t=%0t: got clk=%b en=%b rdy=%b, want clk=%b en=%b rdy=%b",
               $time, clk_o, clk_en_o, div_ready_o, want.clk, want.en, want.rdy);
    end
  endtask

  always @(negedge clk_i) checkOutput();

  task automatic applyStimulus(input bit v, input int d, input bit e, input int cycles);
    div_valid_i = v;
    div_i       = DIV_WIDTH'(d);
`ifdef CLK_INT_DIV_GATE_EN
    en_i = e;
`else
    if (e) div_i = DIV_WIDTH'(d);
`endif
    repeat (cycles) begin
      @(posedge clk_i);
      #2;
    end
  endtask

  task automatic timeoutFail(input string what);
    compared++;
    mismatched++;
    $display("[TB] FAIL wait-%s: condition not seen, want it within bound", what);
  endtask

  initial begin
    bit found;
    #1 rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #2 rst_ni = 1'b1;

    // Value 5 accepted in the very first cycle out of reset
    applyStimulus(1'b1, 5, 1'b1, 1);
    applyStimulus(1'b0, 0, 1'b1, 14);
    applyStimulus(1'b1, 0, 1'b1, 1);
    applyStimulus(1'b0, 0, 1'b1, 8);
    applyStimulus(1'b1, 1, 1'b1, 1);
    applyStimulus(1'b0, 0, 1'b1, 8);
    applyStimulus(1'b1, 2, 1'b1, 1);
    applyStimulus(1'b0, 0, 1'b1, 6);
    applyStimulus(1'b1, 2, 1'b1, 1);
    applyStimulus(1'b0, 0, 1'b1, 4);

    // Back-to-back 8 then a held 3 while the 8 is still pending
    applyStimulus(1'b1, 8, 1'b1, 1);
    applyStimulus(1'b1, 3, 1'b1, 12);
    applyStimulus(1'b0, 0, 1'b1, 20);

    // Asynchronous reset in the middle of a div=6 high phase
    applyStimulus(1'b1, 6, 1'b1, 1);
    applyStimulus(1'b0, 0, 1'b1, 14);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk_i);
      if (clk_o && !clk_en_o) found = 1'b1;
    end
    if (!found) timeoutFail("div6-high");
    #1 rst_ni = 1'b0;
    #1;
    compared++;
    if (clk_o !== 1'b0 || clk_en_o !== 1'b0 || div_ready_o !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL async-reset: got clk=%b en=%b rdy=%b, want clk=0 en=0 rdy=1",
               clk_o, clk_en_o, div_ready_o);
    end
    @(posedge clk_i);
    #2 rst_ni = 1'b1;
    applyStimulus(1'b0, 0, 1'b1, 8);

`ifdef CLK_INT_DIV_GATE_EN
    // Drop en_i during the second cycle of a div=4 period, then re-raise it
    applyStimulus(1'b1, 4, 1'b1, 1);
    applyStimulus(1'b0, 0, 1'b1, 8);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk_i);
      if (clk_en_o) found = 1'b1;
    end
    if (!found) timeoutFail("div4-strobe");
    @(posedge clk_i);
    #2;
    applyStimulus(1'b0, 0, 1'b0, 10);
    applyStimulus(1'b0, 0, 1'b1, 10);
`endif

    for (int k = 0; k < 120; k++)
      applyStimulus($urandom_range(0, 3) == 0, int'($urandom_range(0, 9)),
                    $urandom_range(0, 7) != 0, int'($urandom_range(1, 4)));

    applyStimulus(1'b0, 0, 1'b1, 4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
